// File: rtl/mips_multicycle.sv
// Multicycle MIPS core: one FSM drives fetch/decode/execute/memory/writeback
// over a single registered req/ready memory port.
// Optional feature: define MIPS_BNE_EN to decode bne (opcode 000101).
module mips_multicycle #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned RESET_PC   = 0,
  parameter int unsigned TEST_REG   = 2,
  parameter int unsigned TEST_W     = 16
) (
  input  logic              clk_MIPS,
  input  logic              RST_MIPS,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [TEST_W-1:0] Test_value_MIPS,
  output logic              halted
);

  localparam int unsigned NREGS = 1 << REG_ADDR_W;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MEMADR, S_MEMRD, S_MEMWB,
    S_MEMWR, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_HALT
  } state_t;

  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] mdr_q, mdr_d, a_q, a_d, b_q, b_d, alu_q, alu_d;
  logic [DATA_W-1:0] rf [NREGS];

  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;

  logic              req_d, we_d;
  logic [ADDR_W-1:0] addr_d, issue_addr;
  logic [DATA_W-1:0] wdata_d;

  logic [5:0]            op, funct;
  logic [REG_ADDR_W-1:0] rs, rt, rd;
  logic [DATA_W-1:0]     imm_sext;
  logic                  done, is_mem, take;

  assign op       = ir_q[31:26];
  assign funct    = ir_q[5:0];
  assign rs       = REG_ADDR_W'(ir_q[25:21]);
  assign rt       = REG_ADDR_W'(ir_q[20:16]);
  assign rd       = REG_ADDR_W'(ir_q[15:11]);
  assign imm_sext = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
  assign done     = mem_req & mem_ready;

`ifdef MIPS_BNE_EN
  assign take = (op == OP_BNE) ? (a_q != b_q) : (a_q == b_q);
`else
  assign take = (a_q == b_q);
`endif

  // Next-state, datapath register updates and memory request issue
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    mdr_d    = mdr_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    req_d    = 1'b0;
    we_d     = 1'b0;
    addr_d   = mem_addr;
    wdata_d  = mem_wdata;

    case (state_q)
      S_FETCH: if (done) begin
        ir_d    = mem_rdata[31:0];
        pc_d    = pc_q + ADDR_W'(4);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d   = rf[rs];
        b_d   = rf[rt];
        alu_d = DATA_W'(pc_q) + (imm_sext << 2);
        case (op)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MIPS_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_HALT;
        endcase
      end
      S_EXEC: begin
        state_d = S_ALUWB;
        case (funct)
          6'b100000: alu_d = a_q + b_q;
          6'b100010: alu_d = a_q - b_q;
          6'b100100: alu_d = a_q & b_q;
          6'b100101: alu_d = a_q | b_q;
          6'b101010: alu_d = ($signed(a_q) < $signed(b_q)) ? DATA_W'(1) : '0;
          default:   state_d = S_HALT;
        endcase
      end
      S_ALUWB: begin
        rf_we = 1'b1; rf_waddr = rd; rf_wdata = alu_q;
        state_d = S_FETCH;
      end
      S_MEMADR: begin
        alu_d   = a_q + imm_sext;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: if (done) begin
        mdr_d   = mem_rdata;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        rf_we = 1'b1; rf_waddr = rt; rf_wdata = mdr_q;
        state_d = S_FETCH;
      end
      S_MEMWR: if (done) state_d = S_FETCH;
      S_BRANCH: begin
        if (take) pc_d = ADDR_W'(alu_q);
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        alu_d   = a_q + imm_sext;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        rf_we = 1'b1; rf_waddr = rt; rf_wdata = alu_q;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_d    = {pc_q[ADDR_W-1:28], ir_q[25:0], 2'b00};
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    // A new access is issued one cycle ahead of the state that consumes it;
    // after any completion the request drops for a cycle before re-issuing.
    is_mem     = (state_d == S_FETCH) || (state_d == S_MEMRD) || (state_d == S_MEMWR);
    issue_addr = (state_d == S_FETCH) ? pc_d : ADDR_W'(alu_d);
    if (is_mem && !done) begin
      if (mem_req) begin
        req_d = 1'b1;
        we_d  = mem_we;
      end else if (issue_addr[1:0] != 2'b00) begin
        state_d = S_HALT;
      end else begin
        req_d   = 1'b1;
        we_d    = (state_d == S_MEMWR);
        addr_d  = issue_addr;
        wdata_d = b_d;
      end
    end
  end

  // State, datapath, memory port and register file registers
  always_ff @(posedge clk_MIPS) begin
    if (!RST_MIPS) begin
      state_q         <= S_FETCH;
      pc_q            <= ADDR_W'(RESET_PC);
      ir_q            <= '0;
      mdr_q           <= '0;
      a_q             <= '0;
      b_q             <= '0;
      alu_q           <= '0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      Test_value_MIPS <= '0;
      halted          <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mdr_q     <= mdr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_q     <= alu_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      halted    <= (state_d == S_HALT);
      if (rf_we && rf_waddr != '0) begin
        rf[rf_waddr] <= rf_wdata;
        if (rf_waddr == REG_ADDR_W'(TEST_REG))
          Test_value_MIPS <= rf_wdata[TEST_W-1:0];
      end
    end
  end

endmodule
